// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a run-time loadable pattern
// and length (2..MAX_LEN bits). Overlapping or non-overlapping detection is
// selectable, and matches are counted in a saturating counter.
// Optional macro SEQ_DET_MASK_EN adds a cfg_mask input. Each 1 bit in the mask
// makes that pattern position a don't-care.
// Bit 0 of the pattern and of the history is always the most recent bit.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0010_1101),
    parameter int                 RST_LEN     = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
`ifdef SEQ_DET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    typedef enum logic {FILL, ARMED} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [MAX_LEN-2:0] hist_q, hist_d;   // the incoming bit completes the compare window
    logic [MAX_LEN-1:0] shifted, len_mask, care;
    logic [LEN_W-1:0]   len_q, fill_q, fill_d;
    logic [LEN_W:0]     fill_inc;
    logic               overlap_q, match_q, match_d, cfg_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cfg_ok, hit;

    assign cfg_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    assign shifted  = {hist_q, in};
    assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);

    // Only the low len bits of the pattern take part in the compare
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(len_q)) len_mask[i] = 1'b1;
    end

`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] mask_q;
    // Don't-care mask is reset with the pattern and reloaded with it
    always_ff @(posedge clock) begin
        if (reset)                 mask_q <= '0;
        else if (cfg_load && cfg_ok) mask_q <= cfg_mask;
    end
    assign care = len_mask & ~mask_q;
`else
    assign care = len_mask;
`endif

    // A hit needs the updated history to match and at least len valid bits
    assign hit = (((shifted ^ pattern_q) & care) == '0) && (fill_inc >= {1'b0, len_q});

    // Next-state logic. A cfg_load takes priority and swallows any bit arriving with it.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        match_d = 1'b0;
        if (cfg_load) begin
            if (cfg_ok) begin
                state_d = FILL;
                fill_d  = '0;
                hist_d  = '0;
            end
        end else if (in_valid) begin
            hist_d  = shifted[MAX_LEN-2:0];
            fill_d  = (fill_inc > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_inc[LEN_W-1:0];
            match_d = hit;
            if (hit && !overlap_q) fill_d = '0;
            state_d = (fill_d >= len_q) ? ARMED : FILL;
        end
    end

    // State, history, configuration and the pulse outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FILL;
            fill_q    <= '0;
            hist_q    <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            hist_q    <= hist_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_load && !cfg_ok;
            if (cfg_load && cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
            end
        end
    end

    // Saturating match counter. A clear is applied first, so a clear that
    // coincides with a match pulse leaves the count at 1.
    always_ff @(posedge clock) begin
        if (reset)                         cnt_q <= '0;
        else if (count_clr)                cnt_q <= match_q ? CNT_W'(1) : '0;
        else if (match_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign cfg_err     = cfg_err_q;
    assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. The main instance uses default
// parameters. A second instance with CNT_W=2 shares all inputs and is used
// to exercise counter saturation.
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b1, count_clr = 1'b0;
    logic [7:0] cfg_pattern = '0, cfg_mask = '0;
    logic [3:0] cfg_len = '0;
    logic       match1, err1, armed1, match2, err2, armed2;
    logic [7:0] count1;
    logic [1:0] count2;
    int         checks = 0, failures = 0;

    always #5 clock = ~clock;

    seq_detector_param dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .match(match1), .match_count(count1), .cfg_err(err1), .armed(armed1));

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .match(match2), .match_count(count2), .cfg_err(err2), .armed(armed2));

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); reset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                           input logic [7:0] msk, input logic vb, input logic b);
        cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_mask = msk;
        in_valid = vb; in_bit = b;
        tick();
        cfg_load = 1'b0; in_valid = 1'b0;
    endtask

    // Sends bits[n-1] first. Records match/armed after each bit at the same index.
    // With gap set, an idle cycle follows each bit, and any match seen there is flagged.
    task automatic send_seq(input logic [31:0] bits, input int n, input bit gap,
                            output logic [31:0] ms, output logic [31:0] as, output logic gh);
        ms = '0; as = '0; gh = 1'b0;
        for (int k = n - 1; k >= 0; k--) begin
            in_valid = 1'b1; in_bit = bits[k];
            tick();
            in_valid = 1'b0;
            ms[k] = match1; as[k] = armed1;
            if (gap) begin
                tick();
                if (match1) gh = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (match1 !== 1'b0) begin failures++; $display("FAIL reset_match got=%0b want=0", match1); end
        checks++; if (count1 !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count1); end
        checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err1); end
        checks++; if (armed1 !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b want=0", armed1); end
        checks++; if (count2 !== 2'd0) begin failures++; $display("FAIL reset_count2 got=%0d want=0", count2); end
    endtask

    task automatic test_basic();
        logic [31:0] m, a; logic g;
        do_reset();
        send_seq(32'b101101, 6, 1'b0, m, a, g);
        checks++; if (m[5:0] !== 6'b000001) begin failures++; $display("FAIL basic_match got=%b want=000001", m[5:0]); end
        checks++; if (a[5:0] !== 6'b000001) begin failures++; $display("FAIL basic_armed got=%b want=000001", a[5:0]); end
        idle();
        checks++; if (match1 !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%0b want=0", match1); end
        checks++; if (count1 !== 8'd1) begin failures++; $display("FAIL basic_count got=%0d want=1", count1); end
    endtask

    task automatic test_overlap();
        logic [31:0] m, a; logic g;
        do_reset();
        send_seq(32'b10110110110, 11, 1'b0, m, a, g);
        checks++; if (m[10:0] !== 11'b00000100100) begin failures++; $display("FAIL overlap_match got=%b want=00000100100", m[10:0]); end
        idle();
        checks++; if (count1 !== 8'd2) begin failures++; $display("FAIL overlap_count got=%0d want=2", count1); end
        do_load(8'b0010_1101, 4'd6, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL nonovl_load_err got=%0b want=0", err1); end
        send_seq(32'b10110110110, 11, 1'b0, m, a, g);
        checks++; if (m[10:0] !== 11'b00000100000) begin failures++; $display("FAIL nonovl_match got=%b want=00000100000", m[10:0]); end
        checks++; if (armed1 !== 1'b0) begin failures++; $display("FAIL nonovl_armed got=%0b want=0", armed1); end
        idle();
        checks++; if (count1 !== 8'd3) begin failures++; $display("FAIL nonovl_count got=%0d want=3", count1); end
    endtask

    task automatic test_gapped();
        logic [31:0] m, a; logic g;
        do_load(8'b1100_0011, 4'd8, 1'b1, 8'h00, 1'b0, 1'b0);
        send_seq(32'b11000011, 8, 1'b1, m, a, g);
        checks++; if (m[7:0] !== 8'b00000001) begin failures++; $display("FAIL gapped_match got=%b want=00000001", m[7:0]); end
        checks++; if (a[7:0] !== 8'b00000001) begin failures++; $display("FAIL gapped_armed got=%b want=00000001", a[7:0]); end
        checks++; if (g !== 1'b0) begin failures++; $display("FAIL gapped_idle_match got=%0b want=0", g); end
        checks++; if (count1 !== 8'd4) begin failures++; $display("FAIL gapped_count got=%0d want=4", count1); end
    endtask

    task automatic test_cfg_err();
        logic [31:0] m, a; logic g;
        do_reset();
        do_load(8'hFF, 4'd1, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL err_len1 got=%0b want=1", err1); end
        idle();
        checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%0b want=0", err1); end
        send_seq(32'b101, 3, 1'b0, m, a, g);
        do_load(8'hFF, 4'd9, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL err_len9 got=%0b want=1", err1); end
        send_seq(32'b101, 3, 1'b0, m, a, g);
        checks++; if (m[2:0] !== 3'b001) begin failures++; $display("FAIL err_keeps_history got=%b want=001", m[2:0]); end
        // The bit arriving alongside the load is dropped; a taken bit would add a hit at index 3
        do_load(8'b0010_1101, 4'd6, 1'b1, 8'h00, 1'b1, 1'b1);
        checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL coincident_load_err got=%0b want=0", err1); end
        send_seq(32'b01101101, 8, 1'b0, m, a, g);
        checks++; if (m[7:0] !== 8'b00000001) begin failures++; $display("FAIL coincident_bit_dropped got=%b want=00000001", m[7:0]); end
    endtask

    task automatic test_saturate();
        logic [31:0] m, a; logic g;
        do_reset();
        do_load(8'b0000_0011, 4'd2, 1'b1, 8'h00, 1'b0, 1'b0);
        send_seq(32'b111111, 6, 1'b0, m, a, g);
        checks++; if (m[5:0] !== 6'b011111) begin failures++; $display("FAIL sat_match got=%b want=011111", m[5:0]); end
        idle();
        checks++; if (count2 !== 2'd3) begin failures++; $display("FAIL sat_count2 got=%0d want=3", count2); end
        checks++; if (count1 !== 8'd5) begin failures++; $display("FAIL sat_count1 got=%0d want=5", count1); end
        send_seq(32'b1, 1, 1'b0, m, a, g);
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        checks++; if (count2 !== 2'd1) begin failures++; $display("FAIL clr_with_match2 got=%0d want=1", count2); end
        checks++; if (count1 !== 8'd1) begin failures++; $display("FAIL clr_with_match1 got=%0d want=1", count1); end
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        checks++; if (count1 !== 8'd0) begin failures++; $display("FAIL clr_plain got=%0d want=0", count1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] m, a; logic g;
        do_reset();
        send_seq(32'b10110, 5, 1'b0, m, a, g);
        do_reset();
        checks++; if (armed1 !== 1'b0) begin failures++; $display("FAIL midrst_armed got=%0b want=0", armed1); end
        send_seq(32'b1, 1, 1'b0, m, a, g);
        checks++; if (m[0] !== 1'b0) begin failures++; $display("FAIL midrst_match got=%0b want=0", m[0]); end
        checks++; if (count1 !== 8'd0) begin failures++; $display("FAIL midrst_count got=%0d want=0", count1); end
    endtask

    task automatic test_mask();
        logic [31:0] m, a; logic g;
        do_reset();
`ifdef SEQ_DET_MASK_EN
        do_load(8'b0010_1101, 4'd6, 1'b1, 8'b0000_0100, 1'b0, 1'b0);
        send_seq(32'b101101, 6, 1'b0, m, a, g);
        checks++; if (m[5:0] !== 6'b000001) begin failures++; $display("FAIL mask_exact got=%b want=000001", m[5:0]); end
        do_load(8'b0010_1101, 4'd6, 1'b1, 8'b0000_0100, 1'b0, 1'b0);
        send_seq(32'b101001, 6, 1'b0, m, a, g);
        checks++; if (m[5:0] !== 6'b000001) begin failures++; $display("FAIL mask_dontcare got=%b want=000001", m[5:0]); end
`else
        send_seq(32'b101001, 6, 1'b0, m, a, g);
        checks++; if (m[5:0] !== 6'b000000) begin failures++; $display("FAIL nomask_exact got=%b want=000000", m[5:0]); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_gapped();
        test_cfg_err();
        test_saturate();
        test_reset_mid();
        test_mask();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Serial bit-stream pattern detector with a pattern that can be changed at run time. It is the parametrised successor to the fixed 101101 FSM detector.
- Pattern and length are loaded at run time, up to MAX_LEN bits.
- Overlapping or non-overlapping detection is selectable.
- Matches are counted in a saturating counter.
- Sits on a qualified serial input, e.g. a deserialiser output or a frame-sync hunt path.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of cfg_len. Must hold MAX_LEN (ceil(log2(MAX_LEN+1))).
- CNT_W, 8: width of match_count.
- RST_PATTERN, 8'b0010_1101: pattern after reset. LSB is the most recent bit.
- RST_LEN, 6: length after reset, so the reset pattern is 101101.

Ports:
- clock, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: qualifies in. A bit is sampled only when in_valid=1.
- in, input, 1: serial data bit.
- cfg_load, input, 1: one-cycle strobe that loads cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, input, MAX_LEN: new pattern. Bit 0 is the last bit of the sequence.
- cfg_len, input, LEN_W: new pattern length.
- cfg_overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- count_clr, input, 1: clears match_count.
- match, output, 1: one-cycle pulse on detection.
- match_count, output, CNT_W: saturating count of matches.
- cfg_err, output, 1: one-cycle pulse when a cfg_load is rejected.
- armed, output, 1: history holds at least len valid bits.

Behaviour:
- Reset (synchronous, active-high):
  - pattern=RST_PATTERN, len=RST_LEN, overlap=1.
  - Internal history register cleared; fill counter = 0.
  - Outputs: match=0, match_count=0, cfg_err=0, armed=0.
- State machine has two states:
  - FILL: fill counter < len.
  - ARMED: fill counter >= len; armed=1 in this state only.
  - Reset, accepted cfg_load, or a non-overlap match returns the FSM to FILL with fill counter 0.
- Sampling, on an accepted bit (in_valid=1, no cfg_load in the same cycle):
  - history <= {history[MAX_LEN-2:0], in}.
  - Fill counter increments, saturating at MAX_LEN.
- Compare:
  - Combinational: the low len bits of the shifted history equal the low len bits of pattern, and fill+1 >= len.
  - The compare is evaluated against the updated history.
  - match is registered: it asserts in the cycle after the edge that sampled the completing bit and lasts exactly 1 cycle.
  - Without further accepted bits, no further match occurs.
- Overlap mode (overlap=1): history and fill are kept after a match.
  - Example: 10110110110 with pattern 101101 gives 2 matches.
- Non-overlap mode (overlap=0): fill counter is cleared on a match, so history bits older than the match cannot be reused.
  - Same stream gives 1 match.
- cfg_load handling:
  - Accepted only if 2 <= cfg_len <= MAX_LEN. The new config takes effect from the next cycle; history and fill are cleared.
  - Otherwise the config is unchanged and cfg_err pulses 1 cycle later; history and fill are not disturbed.
  - A bit arriving in the same cycle as any cfg_load is discarded.
  - A match pending from the previous edge still pulses.
- Counting:
  - match_count increments on each match pulse and saturates at all-ones (never wraps).
  - count_clr clears it.
  - count_clr in the same cycle as an increment: result = 1. Clear first, then count.
- Pattern bits above len are ignored in the compare.
- in_valid=0: history, fill and FSM hold.
- Reset asserted mid-sequence: partial history is lost and no match pulse follows reset release.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input cfg_mask [MAX_LEN], loaded with cfg_load.
  - A mask bit of 1 makes the corresponding pattern position don't-care.
  - Reset mask = all zeros.
- Not defined:
  - The port does not exist.
  - The compare is exact on all len bits.

Test Plan:
- Reset, then stream 101101 with in_valid=1 every cycle -> a single match pulse one cycle after the 6th bit; match_count=1; armed rises after the 6th bit.
- Overlap=1, stream 10110110110 -> 2 pulses, after the 6th and 9th bits; count=2. Reload with cfg_overlap=0 and the same stream -> 1 pulse; count=3.
- cfg_load pattern=8'b1100_0011, len=8; stream 11000011 with in_valid toggled 1/0 every other cycle -> match only after the 8th valid bit; invalid cycles hold state.
- cfg_load with cfg_len=1 and cfg_len=9 -> cfg_err pulses each time; the prior pattern still detects 101101. cfg_load coincident with a bit -> that bit is ignored (verified by a match shifted by one bit).
- CNT_W=2: drive 5 matches -> count saturates at 3. count_clr asserted in the same cycle as a match -> count=1.
- Reset asserted after 10110 is received, then 1 -> no match. SEQ_DET_MASK_EN defined with mask=8'b0000_0100 and len=6 -> streams 101101 and 101001 both match.
